// File: rtl/systolic_feeder_4x4.sv
// Loads one 4x4 A tile and one 4x4 B tile, then replays them as diagonally skewed west/north streams.
// Optional shadow bank for back-to-back tiles: define FEEDER_DOUBLE_BUF_EN.
module systolic_feeder_4x4 #(
    parameter int BIT_WIDTH    = 16,
    parameter int FRAC_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*BIT_WIDTH-1:0] in_a_col,
    input  logic [4*BIT_WIDTH-1:0] in_b_row,
    output logic [4*BIT_WIDTH-1:0] west_out,
    output logic [4*BIT_WIDTH-1:0] north_out,
    output logic                   busy,
    output logic                   tile_done
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);

    typedef logic [3:0][3:0][BIT_WIDTH-1:0] tile_t;
    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [1:0]      k_q, k_d;
    logic [2:0]      t_q, t_d;
    logic [DW-1:0]   dc_q, dc_d;
    tile_t           a_q, a_d, b_q, b_d;
    logic            accept;
    logic            busy_d, done_d;
    logic [4*BIT_WIDTH-1:0] west_d, north_d;

`ifdef FEEDER_DOUBLE_BUF_EN
    tile_t           sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_a_acc, sh_b_acc;
    logic [2:0]      sh_cnt_q, sh_cnt_d, sh_cnt_acc;
`endif

    // a[i][k] = A[i][k]; beat k carries column k of A
    function automatic tile_t store_col(input tile_t a, input logic [1:0] k,
                                        input logic [4*BIT_WIDTH-1:0] col);
        tile_t r;
        r = a;
        for (int i = 0; i < 4; i++) r[i][k] = col[(3-i)*BIT_WIDTH +: BIT_WIDTH];
        return r;
    endfunction

    // b[k][j] = B[k][j]; beat k carries row k of B
    function automatic tile_t store_row(input tile_t b, input logic [1:0] k,
                                        input logic [4*BIT_WIDTH-1:0] row);
        tile_t r;
        r = b;
        for (int j = 0; j < 4; j++) r[k][j] = row[(3-j)*BIT_WIDTH +: BIT_WIDTH];
        return r;
    endfunction

    function automatic logic [4*BIT_WIDTH-1:0] skew_west(input tile_t a, input logic [2:0] t);
        logic [4*BIT_WIDTH-1:0] v;
        int d;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            d = int'(t) - i;
            if (d >= 0 && d <= 3) v[(3-i)*BIT_WIDTH +: BIT_WIDTH] = a[i][d[1:0]];
        end
        return v;
    endfunction

    function automatic logic [4*BIT_WIDTH-1:0] skew_north(input tile_t b, input logic [2:0] t);
        logic [4*BIT_WIDTH-1:0] v;
        int d;
        v = '0;
        for (int j = 0; j < 4; j++) begin
            d = int'(t) - j;
            if (d >= 0 && d <= 3) v[(3-j)*BIT_WIDTH +: BIT_WIDTH] = b[d[1:0]][j];
        end
        return v;
    endfunction

`ifdef FEEDER_DOUBLE_BUF_EN
    assign in_ready = (sh_cnt_q != 3'd4);
`else
    assign in_ready = (state_q == IDLE) || (state_q == LOAD);
`endif
    assign accept = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        dc_d    = dc_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef FEEDER_DOUBLE_BUF_EN
        sh_a_acc   = sh_a_q;
        sh_b_acc   = sh_b_q;
        sh_cnt_acc = sh_cnt_q;
        if (accept && (state_q == STREAM || state_q == DRAIN)) begin
            sh_a_acc   = store_col(sh_a_q, sh_cnt_q[1:0], in_a_col);
            sh_b_acc   = store_row(sh_b_q, sh_cnt_q[1:0], in_b_row);
            sh_cnt_acc = sh_cnt_q + 3'd1;
        end
        sh_a_d   = sh_a_acc;
        sh_b_d   = sh_b_acc;
        sh_cnt_d = sh_cnt_acc;
`endif
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    a_d = store_col(a_q, k_q, in_a_col);
                    b_d = store_row(b_q, k_q, in_b_row);
                    if (k_q == 2'd3) begin
                        state_d = STREAM;
                        k_d     = 2'd0;
                        t_d     = 3'd0;
                    end else begin
                        state_d = LOAD;
                        k_d     = k_q + 2'd1;
                    end
                end
            end
            STREAM: begin
                if (t_q == 3'd6) begin
                    state_d = DRAIN;
                    t_d     = 3'd0;
                    dc_d    = '0;
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            DRAIN: begin
                if (dc_q == D_LAST) begin
                    state_d = IDLE;
                    k_d     = 2'd0;
`ifdef FEEDER_DOUBLE_BUF_EN
                    // A beat landing on this very edge still counts toward the shadow tile
                    if (sh_cnt_acc != 3'd0) begin
                        a_d      = sh_a_acc;
                        b_d      = sh_b_acc;
                        sh_cnt_d = 3'd0;
                        if (sh_cnt_acc == 3'd4) begin
                            state_d = STREAM;
                            t_d     = 3'd0;
                        end else begin
                            state_d = LOAD;
                            k_d     = sh_cnt_acc[1:0];
                        end
                    end
`endif
                end else begin
                    dc_d = dc_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state values so step t appears the cycle state holds t
        busy_d  = (state_d == STREAM) || (state_d == DRAIN);
        done_d  = (state_d == DRAIN) && (dc_d == D_LAST);
        west_d  = (state_d == STREAM) ? skew_west(a_d, t_d)  : '0;
        north_d = (state_d == STREAM) ? skew_north(b_d, t_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= 2'd0;
            t_q       <= 3'd0;
            dc_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            busy      <= 1'b0;
            tile_done <= 1'b0;
            west_out  <= '0;
            north_out <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            t_q       <= t_d;
            dc_q      <= dc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            busy      <= busy_d;
            tile_done <= done_d;
            west_out  <= west_d;
            north_out <= north_d;
        end
    end

`ifdef FEEDER_DOUBLE_BUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sh_cnt_q <= 3'd0;
        end else begin
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            sh_cnt_q <= sh_cnt_d;
        end
    end
`endif

endmodule
